// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter multiplexing producers onto one FIFO write port
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);
  localparam logic [BW-1:0] LAST = BW'(MAX_BURST - 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [BW-1:0] burst_cnt;
  logic [IW-1:0] rr_ptr, next_ptr, base, off, sel_id;
  logic [IW:0] sum;
  logic [2*NUM_REQ-1:0] dbl;
  logic any_valid, transfer, release_g;
  assign next_ptr = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  // On release the search starts past the holder; from IDLE it starts at rr_ptr
  assign base = (state == GRANT) ? next_ptr : rr_ptr;
  assign dbl = {req_valid, req_valid} >> base;
  always_comb begin
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) off = dbl[k] ? IW'(k) : off;
  end
  assign sum = {1'b0, base} + {1'b0, off};
  assign sel_id = (sum >= NR) ? IW'(sum - NR) : sum[IW-1:0];
  assign any_valid = |req_valid;
  assign grant_valid = (state == GRANT);
  assign transfer = grant_valid & req_valid[grant_id] & ~fifo_full;
  assign req_ready = (grant_valid & ~fifo_full) ? NUM_REQ'(1) << grant_id : '0;
  assign fifo_wr_en = transfer;
  assign fifo_wr_data = grant_valid ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign release_g = grant_valid & ((transfer & (burst_cnt == LAST)) | ~req_valid[grant_id]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      grant_id  <= '0;
      burst_cnt <= '0;
      rr_ptr    <= '0;
    end else if (state == IDLE) begin
      if (any_valid) begin
        state     <= GRANT;
        grant_id  <= sel_id;
        burst_cnt <= '0;
      end
    end else if (release_g) begin
      rr_ptr    <= next_ptr;
      burst_cnt <= '0;
      if (any_valid) grant_id <= sel_id;
      else state <= IDLE;
    end else if (transfer) burst_cnt <= burst_cnt + 1'b1;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random checks of fifo_wr_arbiter against a round-robin burst model
module tb_fifo_wr_arbiter;
  localparam int N = 4, W = 8, MB = 4;
  logic clk = 0, rst_n = 0, fifo_full = 0;
  logic [N-1:0] req_valid = '0, req_ready, pv;
  logic [N*W-1:0] req_data = '0;
  logic fifo_wr_en, grant_valid;
  logic [W-1:0] fifo_wr_data;
  logic [1:0] grant_id;
  logic [W-1:0] pdata[N];
  int n_chk = 0, n_fail = 0, wr_cnt = 0, acc;
  bit m_g;
  int m_gid, m_cnt, m_ptr;
  always #5 clk = ~clk;
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full), .grant_valid(grant_valid), .grant_id(grant_id)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int pick(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  // One clock: drive inputs, check outputs mid-cycle against the model, advance model past the edge
  task automatic cycle(input logic [N-1:0] v, input logic full, input logic rst, output int a);
    bit xfer, rel;
    int s;
    rst_n = rst;
    req_valid = v;
    fifo_full = full;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = pdata[i];
    #4;
    xfer = rst && m_g && v[m_gid] && !full;
    check("grant_valid", grant_valid, rst && m_g);
    if (rst && m_g) check("grant_id", grant_id, m_gid);
    check("req_ready", req_ready, (rst && m_g && !full) ? (1 << m_gid) : 0);
    check("fifo_wr_en", fifo_wr_en, xfer);
    check("fifo_wr_data", fifo_wr_data, (rst && m_g) ? pdata[m_gid] : 0);
    if (fifo_wr_en) wr_cnt++;
    a = xfer ? m_gid : -1;
    if (xfer) pdata[m_gid]++;
    if (!rst) begin
      m_g = 0; m_gid = 0; m_cnt = 0; m_ptr = 0;
    end else if (!m_g) begin
      s = pick(m_ptr, v);
      if (s >= 0) begin m_g = 1; m_gid = s; m_cnt = 0; end
    end else begin
      rel = (xfer && m_cnt == MB - 1) || !v[m_gid];
      if (rel) begin
        m_ptr = (m_gid + 1) % N;
        s = pick(m_ptr, v);
        if (s >= 0) begin m_gid = s; m_cnt = 0; end
        else m_g = 0;
      end else if (xfer) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic restart(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) pdata[i] = W'(i * 16);
    cycle(v, 0, 0, acc);
    wr_cnt = 0;
  endtask
  initial begin
    @(posedge clk);
    #1;
    restart(4'b1111);
    cycle(4'b1111, 0, 1, acc);
    check("r031_gv", grant_valid, 1);
    check("r031_gid", grant_id, 0);
    restart(4'b0100);
    repeat (9) cycle(4'b0100, 0, 1, acc);
    check("r032_writes", wr_cnt, 8);
    restart(4'b1111);
    repeat (17) cycle(4'b1111, 0, 1, acc);
    check("r033_writes", wr_cnt, 16);
    check("r033_wrap", grant_id, 0);
    restart(4'b0010);
    repeat (3) cycle(4'b0010, 0, 1, acc);
    repeat (3) cycle(4'b0010, 1, 1, acc);
    repeat (2) cycle(4'b0010, 0, 1, acc);
    cycle(4'b0000, 0, 1, acc);
    check("r034_writes", wr_cnt, 4);
    restart(4'b1010);
    repeat (3) cycle(4'b1010, 0, 1, acc);
    cycle(4'b1000, 0, 1, acc);
    check("r035_gid", grant_id, 3);
    repeat (5) cycle(4'b1000, 0, 1, acc);
    check("r035_writes", wr_cnt, 7);
    restart(4'b0001);
    repeat (3) cycle(4'b0001, 0, 1, acc);
    cycle(4'b0001, 0, 0, acc);
    cycle(4'b0110, 0, 1, acc);
    check("r036_gv", grant_valid, 1);
    check("r036_gid", grant_id, 1);
    // Random traffic: producers mostly hold valid until accepted, with occasional drops and resets
    restart(4'b0000);
    pv = '0;
    repeat (3000) begin
      for (int i = 0; i < N; i++)
        if (!pv[i]) pv[i] = ($urandom_range(1) == 1);
        else if ($urandom_range(15) == 0) pv[i] = 1'b0;
      cycle(pv, $urandom_range(3) == 0, $urandom_range(499) != 0, acc);
      if (acc >= 0) pv[acc] = ($urandom_range(1) == 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
